seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Parametrised, time-multiplexed 7-segment display driver for the board's DIGITS-wide display.
- Latches one 4-bit glyph code per digit and cycles the anodes. Decodes each code to segment patterns: 0-9, minus, blank, and "c" (close).
- Adds per-digit blink, global blanking and a frame-complete pulse.
- Sits between the washing-machine control FSM (timers, status codes) and the board pins.

Parameters:
- DIGITS, 8, number of digits scanned; range 1..8.
- CLK_HZ, 100_000_000, input clock frequency.
- SCAN_HZ, 1000, digit-advance rate. SCAN_DIV = CLK_HZ/SCAN_HZ, must be >= 2.
- BLINK_HZ, 2, blink frequency. BLINK_HALF = CLK_HZ/(2*BLINK_HZ), must be >= 1.
- SEG_ACT_HIGH, 1, 1 = segment lit by logic 1; 0 = seg_out inverted.
- AN_ACT_HIGH, 1, 1 = selected anode driven 1; 0 = an_out inverted.

Ports:
- clk  in  1  system clock. Single clock domain.
- rst_n  in  1  reset; asynchronous assert, active-low.
- load  in  1  one-cycle strobe; captures digits_in and blink_mask into shadow registers.
- digits_in  in  4*DIGITS  glyph codes; digit i = bits [4i+3:4i]; digit 0 is rightmost.
- blink_mask  in  DIGITS  1 = digit blinks.
- blank_en  in  1  level; 1 = all segments off while scanning continues.
- seg_out  out  8  segments; bit7 = A ... bit1 = G, bit0 = DP.
- an_out  out  DIGITS  one-hot digit select.
- frame_done  out  1  one-cycle pulse each time the scan wraps from digit DIGITS-1 to 0.

Behaviour:
- Reset (async, rst_n = 0):
  - All shadow codes = 4'hb (blank); blink_mask shadow = 0.
  - div_cnt = 0, digit index = 0, blink_cnt = 0, blink phase = ON.
  - seg_out = all segments inactive; an_out = all anodes inactive; frame_done = 0.
- Release: first tick occurs SCAN_DIV cycles after rst_n rises. Outputs stay inactive until then.
- Glyph table (segments A..G,DP as bit7..bit0, active-high before polarity):
  - 0 = 1111_1100, 1 = 0110_0000, 2 = 1101_1010, 3 = 1111_0010, 4 = 0110_0110
  - 5 = 1011_0110, 6 = 1011_1110, 7 = 1110_0000, 8 = 1111_1110, 9 = 1110_0110
  - a = 0000_0010 (minus), b = 0000_0000 (blank), c = 0001_1010 ("c")
  - d/e/f = 0000_0000
- Shadow load: on a cycle with load = 1, shadows take the inputs at that edge. Display reflects them from the next tick. The in-flight digit is not re-latched mid-slot.
- Scan divider:
  - div_cnt counts 0..SCAN_DIV-1; tick is asserted when div_cnt = SCAN_DIV-1.
  - On tick: index <= (index = DIGITS-1) ? 0 : index+1.
  - seg_out and an_out are registered from the new index on the same edge, so they change exactly at the tick edge.
- frame_done: high for the single cycle following the tick that wraps index to 0.
- Dead time: each digit slot begins with 1 cycle where seg_out is inactive and an_out is already selected. Segments drive from cycle 2 of the slot (anti-ghosting).
- Blink:
  - blink_cnt counts 0..BLINK_HALF-1; at BLINK_HALF-1 the blink phase toggles.
  - While phase = OFF, a selected digit with blink_mask bit = 1 shows blank. Its anode is still selected.
- blank_en: forces seg_out inactive within one cycle. Has no effect on an_out, index or counters.
- Simultaneous load and tick: the newly loaded code is the one displayed for the new index.
- DIGITS = 1: index is held at 0; frame_done pulses every tick.
- Polarity is applied last: seg_out ^ {8{~SEG_ACT_HIGH}} and an_out ^ {DIGITS{~AN_ACT_HIGH}}.

Optional Feature:
- SEG_DP_EN defined:
  - Adds input port dp_in [DIGITS-1:0], latched by load together with the other shadows.
  - seg_out bit0 = dp of the selected digit. DP is subject to blink, blank_en and dead time like the other segments.
- SEG_DP_EN undefined: no dp_in port; seg_out bit0 is constantly inactive.

Test Plan (CLK_HZ=1000, SCAN_HZ=100 -> SCAN_DIV=10; BLINK_HZ=10 -> BLINK_HALF=50; DIGITS=4; both polarities high):
- Reset, then hold rst_n = 0 for 3 cycles and release -> seg_out = 8'h00, an_out = 4'b0000 for 10 cycles; then an_out = 4'b0010. seg_out stays 0 in the dead-time cycle.
- Load digits_in = 16'h3a1c -> slots in order: digit1 = 8'h60, digit2 = 8'h02, digit3 = 8'hF2, digit0 = 8'h1A. frame_done pulses once per 40 cycles, aligned to the wrap onto digit 0.
- blink_mask = 4'b0001 with digit0 code = 8 -> digit0 alternates 8'hFE and 8'h00 every 50 cycles; other digits unaffected.
- blank_en pulsed high for 5 cycles mid-slot -> seg_out = 0 during exactly those cycles; an_out and frame_done timing unchanged.
- rst_n asserted mid-scan with index = 2 -> an_out and seg_out inactive immediately (asynchronous); shadows read 4'hb after release.
- SEG_DP_EN defined, dp_in = 4'b0100, digit2 code = 5 -> digit2 slot shows 8'hB7.

Source files
------------

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Purpose  : Time-multiplexed 7-segment driver with per-digit blink, global
//            blanking and a frame-complete pulse. Define SEG_DP_EN to add
//            the per-digit decimal-point input dp_in.
// Revision : 1.0  initial release
// ============================================================================
module seg_scan_driver #(
   parameter int unsigned DIGITS       = 8,
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned SCAN_HZ      = 1000,
   parameter int unsigned BLINK_HZ     = 2,
   parameter bit          SEG_ACT_HIGH = 1'b1,
   parameter bit          AN_ACT_HIGH  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   digits_in,
   input  logic [DIGITS-1:0]     blink_mask,
`ifdef SEG_DP_EN
   input  logic [DIGITS-1:0]     dp_in,
`endif
   input  logic                  blank_en,
   output logic [7:0]            seg_out,
   output logic [DIGITS-1:0]     an_out,
   output logic                  frame_done
);

   localparam int unsigned SCAN_DIV   = CLK_HZ / SCAN_HZ;
   localparam int unsigned BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
   localparam int unsigned DIV_W      = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
   localparam int unsigned BLK_W      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam int unsigned IDX_W      = (DIGITS > 1)     ? $clog2(DIGITS)     : 1;

   localparam logic [3:0] CODE_BLANK = 4'hb;

   function automatic logic [7:0] glyph(input logic [3:0] code);
      logic [7:0] s;
      case (code)
         4'h0:    s = 8'hFC;
         4'h1:    s = 8'h60;
         4'h2:    s = 8'hDA;
         4'h3:    s = 8'hF2;
         4'h4:    s = 8'h66;
         4'h5:    s = 8'hB6;
         4'h6:    s = 8'hBE;
         4'h7:    s = 8'hE0;
         4'h8:    s = 8'hFE;
         4'h9:    s = 8'hE6;
         4'ha:    s = 8'h02;
         4'hc:    s = 8'h1A;
         default: s = 8'h00;
      endcase
      return s;
   endfunction

   logic [DIV_W-1:0]    div_cnt_q;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [BLK_W-1:0]    blink_cnt_q;
   logic                phase_on_q;
   logic [4*DIGITS-1:0] codes_q, codes_d;
   logic [DIGITS-1:0]   blink_q, blink_d;
   logic [3:0]          cur_code_q, cur_code_d;
   logic                cur_blink_q, cur_blink_d;
   logic [7:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic                frame_q;
   logic                tick, wrap, blink_flip;
   logic                dp_bit;
   logic [7:0]          pattern;

   assign tick       = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
   assign wrap       = (idx_q == IDX_W'(DIGITS - 1));
   assign blink_flip = (blink_cnt_q == BLK_W'(BLINK_HALF - 1));

`ifdef SEG_DP_EN
   logic [DIGITS-1:0] dp_q, dp_d;
   logic              cur_dp_q, cur_dp_d;

   assign dp_d     = load ? dp_in : dp_q;
   assign cur_dp_d = dp_d[idx_d];
   assign dp_bit   = cur_dp_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_q     <= '0;
         cur_dp_q <= 1'b0;
      end else begin
         dp_q <= dp_d;
         if (tick) begin
            cur_dp_q <= cur_dp_d;
         end
      end
   end
`else
   assign dp_bit = 1'b0;
`endif

   // A load coinciding with a tick must feed the new slot, so selection
   // reads the post-load shadow value rather than the registered one.
   always_comb begin
      codes_d     = load ? digits_in  : codes_q;
      blink_d     = load ? blink_mask : blink_q;
      idx_d       = wrap ? '0 : idx_q + IDX_W'(1);
      cur_code_d  = codes_d[{idx_d, 2'b00} +: 4];
      cur_blink_d = blink_d[idx_d];
      an_d        = DIGITS'(1) << idx_d;
   end

   always_comb begin
      pattern    = glyph(cur_code_q);
      pattern[0] = dp_bit;
      if (blank_en || (cur_blink_q && !phase_on_q)) begin
         pattern = '0;
      end
      // The tick cycle is the anti-ghosting dead time of the new slot.
      seg_d = tick ? '0 : pattern;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q   <= '0;
         idx_q       <= '0;
         blink_cnt_q <= '0;
         phase_on_q  <= 1'b1;
         codes_q     <= {DIGITS{CODE_BLANK}};
         blink_q     <= '0;
         cur_code_q  <= CODE_BLANK;
         cur_blink_q <= 1'b0;
         seg_q       <= '0;
         an_q        <= '0;
         frame_q     <= 1'b0;
      end else begin
         codes_q     <= codes_d;
         blink_q     <= blink_d;
         div_cnt_q   <= tick ? '0 : div_cnt_q + DIV_W'(1);
         blink_cnt_q <= blink_flip ? '0 : blink_cnt_q + BLK_W'(1);
         if (blink_flip) begin
            phase_on_q <= ~phase_on_q;
         end
         seg_q   <= seg_d;
         frame_q <= tick && wrap;
         if (tick) begin
            idx_q       <= idx_d;
            an_q        <= an_d;
            cur_code_q  <= cur_code_d;
            cur_blink_q <= cur_blink_d;
         end
      end
   end

   assign seg_out    = seg_q ^ {8{~SEG_ACT_HIGH}};
   assign an_out     = an_q ^ {DIGITS{~AN_ACT_HIGH}};
   assign frame_done = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Purpose  : Self-checking bench: vector table, reset corners and random
//            stimulus against a cycle-count based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_driver;

   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 10;
   localparam int BLINK_H  = 50;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic [15:0] digits_in;
   logic [3:0]  blink_mask;
   logic        blank_en;
   logic [7:0]  seg_out;
   logic [3:0]  an_out;
   logic        frame_done;
   logic [7:0]  seg1;
   logic [0:0]  an1;
   logic        fd1;
`ifdef SEG_DP_EN
   logic [3:0]  dp_in;
`endif

   always #5 clk = ~clk;

   seg_scan_driver #(
      .DIGITS(DIGITS), .CLK_HZ(1000), .SCAN_HZ(100), .BLINK_HZ(10),
      .SEG_ACT_HIGH(1'b1), .AN_ACT_HIGH(1'b1)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
      .blink_mask(blink_mask),
`ifdef SEG_DP_EN
      .dp_in(dp_in),
`endif
      .blank_en(blank_en), .seg_out(seg_out), .an_out(an_out),
      .frame_done(frame_done)
   );

   // Single-digit instance: scan divider of 2, index pinned at 0.
   seg_scan_driver #(
      .DIGITS(1), .CLK_HZ(4), .SCAN_HZ(2), .BLINK_HZ(1),
      .SEG_ACT_HIGH(1'b1), .AN_ACT_HIGH(1'b1)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in[3:0]),
      .blink_mask(blink_mask[0:0]),
`ifdef SEG_DP_EN
      .dp_in(dp_in[0:0]),
`endif
      .blank_en(blank_en), .seg_out(seg1), .an_out(an1), .frame_done(fd1)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state: n = clock edges since reset release.
   int         n;
   logic [3:0] sh_code [DIGITS];
   logic       sh_blink[DIGITS];
   logic       sh_dp   [DIGITS];
   logic [3:0] slot_code;
   logic       slot_blink;
   logic       slot_dp;
   logic [7:0] exp_seg;
   logic [3:0] exp_an;
   logic       exp_fd;

   logic [7:0] glyph_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6,
                                  8'hBE, 8'hE0, 8'hFE, 8'hE6, 8'h02, 8'h00,
                                  8'h1A, 8'h00, 8'h00, 8'h00};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at n=%0d t=%0t: got %h, expected %h", name, n, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      n = 0;
      for (int i = 0; i < DIGITS; i++) begin
         sh_code[i]  = 4'hb;
         sh_blink[i] = 1'b0;
         sh_dp[i]    = 1'b0;
      end
      slot_code  = 4'hb;
      slot_blink = 1'b0;
      slot_dp    = 1'b0;
      exp_seg    = 8'h00;
      exp_an     = 4'h0;
      exp_fd     = 1'b0;
   endtask

   task automatic model_edge();
      bit tick;
      bit phase_on;
      int idx;
      n++;
      tick = (n % SCAN_DIV) == 0;
      idx  = (n / SCAN_DIV) % DIGITS;
      if (load) begin
         for (int i = 0; i < DIGITS; i++) begin
            sh_code[i]  = digits_in[4*i +: 4];
            sh_blink[i] = blink_mask[i];
`ifdef SEG_DP_EN
            sh_dp[i]    = dp_in[i];
`endif
         end
      end
      if (tick) begin
         slot_code  = sh_code[idx];
         slot_blink = sh_blink[idx];
         slot_dp    = sh_dp[idx];
      end
      phase_on = (((n - 1) / BLINK_H) % 2) == 0;
      exp_an   = (n >= SCAN_DIV) ? 4'(1 << idx) : 4'h0;
      exp_fd   = tick && (idx == 0);
      if (n < SCAN_DIV || tick || blank_en || (slot_blink && !phase_on)) begin
         exp_seg = 8'h00;
      end else begin
         exp_seg    = glyph_tab[slot_code];
         exp_seg[0] = slot_dp;
      end
   endtask

   task automatic step(input int cycles);
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk);
         if (rst_n) model_edge();
         #1;
         chk("seg_out", seg_out, exp_seg);
         chk("an_out", an_out, exp_an);
         chk("frame_done", frame_done, exp_fd);
         chk("d1_an_out", an1, (n >= 2) ? 1 : 0);
         chk("d1_frame_done", fd1, (n >= 2 && n % 2 == 0) ? 1 : 0);
         if (n % 2 == 0) chk("d1_dead_time", seg1, 8'h00);
         load = 1'b0;
      end
   endtask

   typedef struct {
      logic        ld;
      logic [15:0] dig;
      logic [3:0]  msk;
      logic        blk;
      int          cyc;
      logic [7:0]  seg;
      logic [3:0]  an;
      logic        fd;
   } vec_t;

   vec_t tbl[15];

   initial begin
      tbl[0]  = '{1'b0, 16'h0000, 4'h0, 1'b0,  9, 8'h00, 4'b0000, 1'b0};
      tbl[1]  = '{1'b1, 16'h3a1c, 4'h0, 1'b0,  1, 8'h00, 4'b0010, 1'b0};
      tbl[2]  = '{1'b0, 16'h3a1c, 4'h0, 1'b0,  1, 8'h60, 4'b0010, 1'b0};
      tbl[3]  = '{1'b0, 16'h3a1c, 4'h0, 1'b0,  9, 8'h00, 4'b0100, 1'b0};
      tbl[4]  = '{1'b0, 16'h3a1c, 4'h0, 1'b0,  1, 8'h02, 4'b0100, 1'b0};
      tbl[5]  = '{1'b0, 16'h3a1c, 4'h0, 1'b0, 10, 8'hF2, 4'b1000, 1'b0};
      tbl[6]  = '{1'b0, 16'h3a1c, 4'h0, 1'b0,  9, 8'h00, 4'b0001, 1'b1};
      tbl[7]  = '{1'b0, 16'h3a1c, 4'h0, 1'b0,  1, 8'h1A, 4'b0001, 1'b0};
      tbl[8]  = '{1'b0, 16'h3a1c, 4'h0, 1'b1,  5, 8'h00, 4'b0001, 1'b0};
      tbl[9]  = '{1'b0, 16'h3a1c, 4'h0, 1'b0,  1, 8'h1A, 4'b0001, 1'b0};
      tbl[10] = '{1'b1, 16'h3a18, 4'h1, 1'b0,  1, 8'h1A, 4'b0001, 1'b0};
      tbl[11] = '{1'b0, 16'h3a18, 4'h1, 1'b0, 32, 8'h00, 4'b0001, 1'b1};
      tbl[12] = '{1'b0, 16'h3a18, 4'h1, 1'b0,  1, 8'h00, 4'b0001, 1'b0};
      tbl[13] = '{1'b0, 16'h3a18, 4'h1, 1'b0, 40, 8'hFE, 4'b0001, 1'b0};
      tbl[14] = '{1'b0, 16'h3a18, 4'h1, 1'b0,  1, 8'hFE, 4'b0001, 1'b0};

      load       = 1'b0;
      digits_in  = 16'h0;
      blink_mask = 4'h0;
      blank_en   = 1'b0;
`ifdef SEG_DP_EN
      dp_in      = 4'h0;
`endif
      rst_n = 1'b1;
      model_reset();
      #2 rst_n = 1'b0;
      model_reset();
      step(3);
      chk("rst_seg", seg_out, 8'h00);
      chk("rst_an", an_out, 4'h0);
      chk("rst_fd", frame_done, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         load       = tbl[i].ld;
         digits_in  = tbl[i].dig;
         blink_mask = tbl[i].msk;
         blank_en   = tbl[i].blk;
         step(tbl[i].cyc);
         chk($sformatf("tbl%0d_seg", i), seg_out, tbl[i].seg);
         chk($sformatf("tbl%0d_an", i), an_out, tbl[i].an);
         chk($sformatf("tbl%0d_fd", i), frame_done, tbl[i].fd);
      end

      // Asynchronous reset in the middle of the digit-2 slot.
      step(20);
      chk("pre_rst_an", an_out, 4'b0100);
      chk("pre_rst_seg", seg_out, 8'h02);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst_an", an_out, 4'h0);
      chk("async_rst_seg", seg_out, 8'h00);
      step(3);
      rst_n = 1'b1;
      step(10);
      chk("rel_tick_an", an_out, 4'b0010);
      chk("rel_tick_seg", seg_out, 8'h00);
      step(1);
      chk("rel_shadow_blank", seg_out, 8'h00);

      for (int c = 0; c < 800; c++) begin
         load       = ($urandom_range(0, 15) == 0);
         digits_in  = 16'($urandom);
         blink_mask = 4'($urandom);
         blank_en   = ($urandom_range(0, 7) == 0);
`ifdef SEG_DP_EN
         dp_in      = 4'($urandom);
`endif
         step(1);
      end

`ifdef SEG_DP_EN
      load       = 1'b1;
      digits_in  = 16'h0500;
      blink_mask = 4'h0;
      blank_en   = 1'b0;
      dp_in      = 4'b0100;
      step(1);
      begin
         int budget = 60;
         while (!((n % SCAN_DIV) == 1 && ((n / SCAN_DIV) % DIGITS) == 2) && budget > 0) begin
            step(1);
            budget--;
         end
         chk("dp_wait_budget", (budget > 0) ? 1 : 0, 1);
         chk("dp_slot_seg", seg_out, 8'hB7);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
